idct_vecrot_mult: RTL

// - Vector-rotation stage of the IDCT datapath: F1(k) = (D1(k) - j*D1(N+2-k)) * exp(j*pi*(k-1)/2N), k=1..N.
// - Buffers one real DCT frame, then replays it as (k, N-k) pairs.
// - Drives the cos/sin coefficient generator and multiplies by its Q16 outputs.
// - Streams complex F1 to the downstream IFFT. Sits between DCT-coefficient input and IFFT.

---
 rtl/idct_vecrot_mult.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/idct_vecrot_mult.sv
// IDCT vector-rotation stage: buffers a real DCT frame, replays (k, N-k) pairs against cos/sin coefficients.
// Define IDCT_VECROT_SAT_EN to clamp outputs; otherwise results wrap to wDataOut bits.
module idct_vecrot_mult #(
  parameter int wDataIn  = 18,
  parameter int wCoef    = 18,
  parameter int wDataOut = 18,
  parameter int NMAX     = 2048
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [11:0]                fftpts_in,
  input  logic                       sink_valid,
  input  logic                       sink_sop,
  input  logic                       sink_eop,
  input  logic signed [wDataIn-1:0]  sink_data,
  output logic                       sink_ready,
  output logic                       coef_valid,
  output logic [11:0]                coef_fftpts,
  input  logic [wCoef-1:0]           coef_cos,
  input  logic [wCoef-1:0]           coef_sin,
  output logic                       source_valid,
  output logic                       source_sop,
  output logic                       source_eop,
  output logic signed [wDataOut-1:0] source_real,
  output logic signed [wDataOut-1:0] source_imag,
  output logic                       frame_err
);

  localparam int AW = $clog2(NMAX);
  localparam int PW = wDataIn + wCoef;
  localparam int SW = PW + 1 - 16;
  localparam logic signed [PW:0]   RND  = {{(PW-15){1'b0}}, 1'b1, 15'b0};
  localparam logic signed [SW-1:0] MAXV = {{(SW-wDataOut+1){1'b0}}, {(wDataOut-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-wDataOut+1){1'b1}}, {(wDataOut-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, WRITE, READ, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [11:0]       n_q, n_d;
  logic [AW-1:0]     wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic [1:0]        fcnt_q, fcnt_d;
  logic              err_d, we;
  logic [AW-1:0]     waddr, baddr;
  logic [11:0]       bsub;

  logic signed [wDataIn-1:0] mem [NMAX];
  logic signed [wDataIn-1:0] a_q, b_q;
  logic signed [PW-1:0]      ae, be, ce, se;
  logic signed [PW-1:0]      p_ac_q, p_bs_q, p_as_q, p_bc_q;
  logic signed [PW:0]        re_s, im_s;
  logic signed [SW-1:0]      re_t, im_t;
  logic signed [wDataOut-1:0] re_o, im_o;
  logic v1_q, sop1_q, eop1_q, v2_q, sop2_q, eop2_q;
  logic unused_bits;

  function automatic logic n_ok(input logic [11:0] n);
    return (n[4:0] == '0) && (n[11:5] != '0) && ((n & (n - 12'd1)) == '0);
  endfunction

  assign sink_ready  = (state_q == IDLE) || (state_q == WRITE);
  assign coef_valid  = (state_q == READ);
  assign coef_fftpts = n_q;
  assign bsub        = n_q - 12'(rcnt_q);
  assign baddr       = bsub[AW-1:0];

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    fcnt_d  = fcnt_q;
    err_d   = 1'b0;
    we      = 1'b0;
    waddr   = wcnt_q;
    case (state_q)
      IDLE: if (sink_valid && sink_sop) begin
        if (!n_ok(fftpts_in) || sink_eop) err_d = 1'b1;
        else begin
          n_d = fftpts_in; we = 1'b1; waddr = '0; wcnt_d = AW'(1); state_d = WRITE;
        end
      end
      WRITE: if (sink_valid) begin
        // A new sop aborts the current frame and starts over with this sample as k=1
        if (sink_sop) begin
          err_d = 1'b1;
          if (n_ok(fftpts_in)) begin
            n_d = fftpts_in; we = 1'b1; waddr = '0; wcnt_d = AW'(1);
          end else state_d = IDLE;
        end else begin
          we = 1'b1;
          if (12'(wcnt_q) == n_q - 12'd1) begin
            if (sink_eop) begin state_d = READ; rcnt_d = '0; end
            else begin err_d = 1'b1; state_d = IDLE; end
          end else if (sink_eop) begin
            err_d = 1'b1; state_d = IDLE;
          end else wcnt_d = wcnt_q + 1'b1;
        end
      end
      READ: if (12'(rcnt_q) == n_q - 12'd1) begin
        state_d = FLUSH; fcnt_d = '0;
      end else rcnt_d = rcnt_q + 1'b1;
      default: if (fcnt_q == 2'd2) state_d = IDLE;
               else fcnt_d = fcnt_q + 1'b1;
    endcase
  end

  always_comb begin
    ae = {{(PW-wDataIn){a_q[wDataIn-1]}}, a_q};
    be = {{(PW-wDataIn){b_q[wDataIn-1]}}, b_q};
    ce = {{(PW-wCoef){1'b0}}, coef_cos};
    se = {{(PW-wCoef){1'b0}}, coef_sin};
    re_s = {p_ac_q[PW-1], p_ac_q} + {p_bs_q[PW-1], p_bs_q} + RND;
    im_s = {p_as_q[PW-1], p_as_q} - {p_bc_q[PW-1], p_bc_q} + RND;
    re_t = re_s[PW:16];
    im_t = im_s[PW:16];
`ifdef IDCT_VECROT_SAT_EN
    re_o = (re_t > MAXV) ? MAXV[wDataOut-1:0] : (re_t < MINV) ? MINV[wDataOut-1:0] : re_t[wDataOut-1:0];
    im_o = (im_t > MAXV) ? MAXV[wDataOut-1:0] : (im_t < MINV) ? MINV[wDataOut-1:0] : im_t[wDataOut-1:0];
    unused_bits = ^{re_s[15:0], im_s[15:0], bsub[11:AW]};
`else
    re_o = re_t[wDataOut-1:0];
    im_o = im_t[wDataOut-1:0];
    unused_bits = ^{re_s[15:0], im_s[15:0], bsub[11:AW], re_t[SW-1:wDataOut], im_t[SW-1:wDataOut],
                    MAXV, MINV};
`endif
  end

  // Buffer and datapath carry no reset; only control and outputs are reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= sink_data;
    a_q    <= mem[rcnt_q];
    b_q    <= (rcnt_q == '0) ? '0 : mem[baddr];
    p_ac_q <= ae * ce;
    p_bs_q <= be * se;
    p_as_q <= ae * se;
    p_bc_q <= be * ce;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      n_q          <= 12'd2048;
      wcnt_q       <= '0;
      rcnt_q       <= '0;
      fcnt_q       <= '0;
      v1_q         <= 1'b0;
      sop1_q       <= 1'b0;
      eop1_q       <= 1'b0;
      v2_q         <= 1'b0;
      sop2_q       <= 1'b0;
      eop2_q       <= 1'b0;
      source_valid <= 1'b0;
      source_sop   <= 1'b0;
      source_eop   <= 1'b0;
      source_real  <= '0;
      source_imag  <= '0;
      frame_err    <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      wcnt_q       <= wcnt_d;
      rcnt_q       <= rcnt_d;
      fcnt_q       <= fcnt_d;
      v1_q         <= coef_valid;
      sop1_q       <= coef_valid && (rcnt_q == '0);
      eop1_q       <= coef_valid && (12'(rcnt_q) == n_q - 12'd1);
      v2_q         <= v1_q;
      sop2_q       <= sop1_q;
      eop2_q       <= eop1_q;
      source_valid <= v2_q;
      source_sop   <= sop2_q;
      source_eop   <= eop2_q;
      source_real  <= v2_q ? re_o : '0;
      source_imag  <= v2_q ? im_o : '0;
      frame_err    <= err_d;
    end
  end

endmodule
